// File: rtl/down_sampler_if.sv
// Pixel stream bundle around the octave down-sampler.
// The slave side is the decimator. The master side is the blur stage plus the downstream FIFO.
interface down_sampler_if #(
    parameter int PIX_W = 8
);
    logic             valid;
    logic             sof;
    logic [PIX_W-1:0] din;
    logic             full;
    logic             ready;
    logic [PIX_W-1:0] dout;
    logic             valid_out;
    logic             frame_done;

    modport master (
        output valid, sof, din, full,
        input  ready, dout, valid_out, frame_done
    );

    modport slave (
        input  valid, sof, din, full,
        output ready, dout, valid_out, frame_done
    );
endinterface

// File: rtl/down_sampler.sv
// Streaming 2:1 decimator in both dimensions, placed between SIFT octaves.
// Define DOWN_SAMPLE_AVG_EN to use a 2x2 box average instead of keeping one pixel out of four.
module down_sampler #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input logic           clk,
    input logic           rst_n,
    down_sampler_if.slave bus
);
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]    col_q, col_d, cur_col;
    logic [RW-1:0]    row_q, row_d, cur_row;
    logic [PIX_W-1:0] dout_q, dout_d, pix;
    logic             valid_out_q, valid_out_d;
    logic             frame_done_q, frame_done_d;
    logic             accept, keep, last;

    assign bus.ready      = ~bus.full;
    assign accept         = bus.valid & ~bus.full;
    assign bus.dout       = dout_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.frame_done = frame_done_q;

    // sof forces the pixel to (0,0) so a mid-frame re-sync takes effect on that same pixel
    always_comb begin
        cur_col = bus.sof ? '0 : col_q;
        cur_row = bus.sof ? '0 : row_q;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

`ifdef DOWN_SAMPLE_AVG_EN
    localparam int BD = IMG_W / 2;
    localparam int BW = (BD > 1) ? $clog2(BD) : 1;

    logic [PIX_W:0]   line_buf_q [BD];
    logic [PIX_W-1:0] pair_q, pair_d;
    logic [PIX_W:0]   pair_sum;
    logic [PIX_W+1:0] box_sum;
    logic [BW-1:0]    buf_idx;
    logic             buf_we;

    always_comb begin
        buf_idx  = BW'(cur_col >> 1);
        pair_sum = {1'b0, pair_q} + {1'b0, bus.din};
        // Four pixels plus rounding peak at 4*(2^PIX_W-1)+2, so PIX_W+2 bits never wrap
        box_sum  = {1'b0, line_buf_q[buf_idx]} + {1'b0, pair_sum} + (PIX_W+2)'(2);
        pix      = PIX_W'(box_sum >> 2);
        keep     = cur_col[0] & cur_row[0];
        last     = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        pair_d   = (accept & ~cur_col[0]) ? bus.din : pair_q;
        buf_we   = accept & cur_col[0] & ~cur_row[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pair_q <= '0;
        else        pair_q <= pair_d;
    end

    // An even row always refills an entry before the odd row reads it, so no reset is needed here
    always_ff @(posedge clk) begin
        if (buf_we) line_buf_q[buf_idx] <= pair_sum;
    end
`else
    localparam logic [CW-1:0] COL_PEN = CW'(IMG_W - 2);
    localparam logic [RW-1:0] ROW_PEN = RW'(IMG_H - 2);

    always_comb begin
        pix  = bus.din;
        keep = ~cur_col[0] & ~cur_row[0];
        last = (cur_col == COL_PEN) && (cur_row == ROW_PEN);
    end
`endif

    always_comb begin
        valid_out_d  = accept & keep;
        frame_done_d = accept & keep & last;
        dout_d       = (accept & keep) ? pix : dout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            dout_q       <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            dout_q       <= dout_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule
